float_div_12: RTL and testbench
===============================

Name: float_div_12

Overview:
- Iterative floating-point divider for the 12-bit float format: sign[11], exponent[10:6] biased by 15, mantissa[5:0] with a hidden leading 1.
- Computes data_1_i / data_2_i. It is the inverse companion of the 12-bit multiplier in the arithmetic datapath.
- Uses valid/ready handshakes on both sides, with constant latency.
- Intended for normalisation and scaling stages of the neural processor.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 6, stored mantissa width.
- EXP_BIAS, 15, exponent bias.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operands present.
- in_ready_o  out  1  divider idle; the operand pair is accepted when in_valid_i & in_ready_o.
- data_1_i  in  12  dividend.
- data_2_i  in  12  divisor.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts the result.
- data_div_o  out  12  quotient {sign, exp, mant}.
- div_zero_o  out  1  the divisor was zero; valid while out_valid_o is high.

Behaviour:
- Reset values: out_valid_o=0, data_div_o=0, div_zero_o=0, FSM=IDLE, in_ready_o=1. Reset is asynchronous and may be asserted in any state; it aborts the operation in flight and leaves no residual result.
- States and transitions:
  - IDLE: in_ready_o=1. On accept, latch the operands and go to DIV with the iteration counter at 7.
  - DIV: 8 restoring-division iterations, one quotient bit per cycle, MSB first. Dividend is {1,man_a}<<7; divisor is {1,man_b}. The counter decrements each cycle; go to NORM after the counter-0 cycle.
  - NORM: one cycle. Normalise the quotient and register the result. Go to DONE.
  - DONE: out_valid_o=1, with outputs held stable. On out_valid_o & out_ready_i, go to IDLE.
- Latency and throughput:
  - out_valid_o rises 10 clocks after the accept edge: 1 transition into DIV, 8 DIV, 1 NORM.
  - Minimum throughput is one result per 11 cycles.
  - in_ready_o=0 in DIV, NORM and DONE; in_valid_i is ignored there.
- Arithmetic:
  - sign = sa ^ sb.
  - The 8-bit quotient q is in [64,255].
  - If q[7]=1: mant=q[6:1] and exp = ea - eb + EXP_BIAS.
  - Else: mant=q[5:0] and exp = ea - eb + EXP_BIAS - 1.
  - The exponent is computed in 7-bit signed arithmetic. The mantissa is truncated, with no rounding.
- Special cases (operands are otherwise all treated as normalised):
  - Divisor zero (exp=0, mant=0): result {sign,5'h1F,6'h3F}, div_zero_o=1.
  - Dividend zero with nonzero divisor: result {sign,11'h0}.
  - Special cases keep the full 10-cycle latency.
- Exponent out of range (result exponent <0 or >31): handling depends on FLOAT_DIV_SAT_EN.

Optional Feature:
- Macro: FLOAT_DIV_SAT_EN.
- Defined:
  - Exponent >31 gives {sign,5'h1F,6'h3F}.
  - Exponent <0, or exponent 0 from a nonzero dividend, gives {sign,11'h0}.
- Undefined: the low 5 bits of the exponent are kept (wrap modulo 32), matching the multiplier's unchecked behaviour.

Decomposition:
- Shared package float12_pkg holds:
  - EXP_W, MAN_W, EXP_BIAS.
  - The FSM state enum {IDLE, DIV, NORM, DONE}.
  - Field-slice helper functions for sign, exponent and mantissa.
  - The zero-detect function.
- One sub-module, mant_div_restoring, holds the 7-bit restoring-division core. Its interface:
  - Inputs: start, divisor, dividend.
  - Outputs: 8-bit quotient, done.
  - It owns the partial remainder and the counter.
  - The top level owns the handshake, exponent, sign and normalisation.

Test Plan:
- 1.0/1.0, with 12'h3C0/12'h3C0 accepted at edge 0 -> out_valid_o rises after edge 10; data_div_o=12'h3C0, div_zero_o=0.
- 3.0/1.5 (12'h420/12'h3E0) -> 12'h400, the q[7]=1 path. Then -1.0/1.5 (12'hBC0/12'h3E0) -> 12'hB95, the q[7]=0 path with mant 0x15 and exp 14.
- 12'h3C0/12'h000 -> data_div_o=12'h7FF, div_zero_o=1. Then 12'h000/12'h3C0 -> 12'h000, div_zero_o=0.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o -> output stable and in_ready_o=0. A second in_valid_i pulse during that window is not accepted. Release -> IDLE on the next edge.
- Assert rst_i asynchronously in the 4th DIV cycle -> out_valid_o=0 and in_ready_o=1 immediately, without waiting for a clock. A following 12'h420/12'h3E0 operation returns 12'h400.
- 12'h780/12'h040 (exponent 44):
  - With FLOAT_DIV_SAT_EN -> 12'h7FF.
  - Without -> 12'h300.

Source files
------------

// File: rtl/float12_pkg.sv
// Shared definitions for the 12-bit float datapath: field widths, FSM states,
// field-slice helpers and zero detection.
package float12_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 6;
  localparam int EXP_BIAS = 15;
  localparam int WORD_W   = 1 + EXP_W + MAN_W;
  localparam int QUO_W    = MAN_W + 2;
  localparam int CNT_W    = $clog2(QUO_W);
  localparam int EXP_SW   = EXP_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic fieldSign(input logic [WORD_W-1:0] x);
    return x[WORD_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fieldExp(input logic [WORD_W-1:0] x);
    return x[WORD_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] fieldMant(input logic [WORD_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Zero is the all-zero exponent and mantissa, either sign.
  function automatic logic isZero(input logic [WORD_W-1:0] x);
    return (fieldExp(x) == '0) && (fieldMant(x) == '0);
  endfunction

endpackage

// File: rtl/float_div_12_mant_div.sv
// Restoring division core: produces floor((dividend << 7) / divisor), one
// quotient bit per cycle MSB first, with a one-cycle done pulse at the end.
module mant_div_restoring
  import float12_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [MAN_W:0]   divisor_i,
  input  logic [MAN_W:0]   dividend_i,
  output logic [QUO_W-1:0] quotient_o,
  output logic             done_o
);

  logic [QUO_W-1:0] rem_q, rem_d;
  logic [QUO_W-1:0] remKeep;
  logic [MAN_W:0]   divisor_q;
  logic [QUO_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             geq;

  // Remainder is kept one bit wider than the divisor since it is doubled each step.
  always_comb begin
    geq     = rem_q >= {1'b0, divisor_q};
    remKeep = geq ? (rem_q - {1'b0, divisor_q}) : rem_q;
    rem_d   = remKeep << 1;
    quot_d  = {quot_q[QUO_W-2:0], geq};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q     <= {1'b0, dividend_i};
        divisor_q <= divisor_i;
        quot_q    <= '0;
        cnt_q     <= CNT_W'(QUO_W - 1);
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_o = quot_q;
  assign done_o     = done_q;

endmodule

// File: rtl/float_div_12.sv
// Iterative 12-bit float divider with valid/ready handshakes and fixed latency.
// Define FLOAT_DIV_SAT_EN to saturate out-of-range exponents instead of wrapping.
module float_div_12
  import float12_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] data_1_i,
  input  logic [WORD_W-1:0] data_2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] data_div_o,
  output logic              div_zero_o
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] opA_q, opB_q;
  logic [WORD_W-1:0] result_q, result_d;
  logic              divZero_q, divZero_d;
  logic              accept;
  logic              coreDone;
  logic [QUO_W-1:0]  quotient;
  logic              resSign;
  logic              normAdj;
  logic [MAN_W-1:0]  mantNorm;
  logic [EXP_W-1:0]  expA, expB;
`ifdef FLOAT_DIV_SAT_EN
  logic signed [EXP_SW-1:0] expWide;
`else
  logic [EXP_W-1:0]  expField;
`endif

  assign accept = in_valid_i & in_ready_o;

  mant_div_restoring uCore (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (accept),
    .divisor_i  ({1'b1, fieldMant(data_2_i)}),
    .dividend_i ({1'b1, fieldMant(data_1_i)}),
    .quotient_o (quotient),
    .done_o     (coreDone)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (coreDone) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opA_q <= '0;
      opB_q <= '0;
    end else if (accept) begin
      opA_q <= data_1_i;
      opB_q <= data_2_i;
    end
  end

  // A quotient below 128 means the mantissa ratio was under 1: shift once, borrow one from the exponent.
  always_comb begin
    resSign   = fieldSign(opA_q) ^ fieldSign(opB_q);
    expA      = fieldExp(opA_q);
    expB      = fieldExp(opB_q);
    normAdj   = ~quotient[QUO_W-1];
    mantNorm  = quotient[QUO_W-1] ? quotient[MAN_W:1] : quotient[MAN_W-1:0];
    divZero_d = 1'b0;
`ifdef FLOAT_DIV_SAT_EN
    expWide  = $signed({2'b00, expA}) - $signed({2'b00, expB})
             + $signed(EXP_SW'(EXP_BIAS)) - $signed({{(EXP_SW-1){1'b0}}, normAdj});
    result_d = {resSign, expWide[EXP_W-1:0], mantNorm};
    if (expWide[EXP_SW-1] || (expWide == '0))
      result_d = {resSign, {(WORD_W-1){1'b0}}};
    else if (expWide[EXP_SW-2:EXP_W] != '0)
      result_d = {resSign, {(WORD_W-1){1'b1}}};
`else
    expField = expA - expB + EXP_W'(EXP_BIAS) - {{(EXP_W-1){1'b0}}, normAdj};
    result_d = {resSign, expField, mantNorm};
`endif
    if (isZero(opB_q)) begin
      result_d  = {resSign, {(WORD_W-1){1'b1}}};
      divZero_d = 1'b1;
    end else if (isZero(opA_q)) begin
      result_d  = {resSign, {(WORD_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q  <= '0;
      divZero_q <= 1'b0;
    end else if (state_q == NORM) begin
      result_q  <= result_d;
      divZero_q <= divZero_d;
    end
  end

  assign data_div_o = result_q;
  assign div_zero_o = divZero_q;

endmodule

// File: tb/tb_float_div_12.sv
// Directed bench for float_div_12 with a scoreboard queue of expected results.
// Expected values for the out-of-range case follow FLOAT_DIV_SAT_EN.
module tb_float_div_12;

  typedef struct {
    logic [11:0] data;
    logic        dz;
    string       tag;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [11:0] dataA;
  logic [11:0] dataB;
  logic        outValid;
  logic        outReady;
  logic [11:0] dataDiv;
  logic        divZero;

  int checksTotal  = 0;
  int checksPassed = 0;
  expect_t expQ[$];

  always #5 clk = ~clk;

  float_div_12 dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .data_1_i    (dataA),
    .data_2_i    (dataB),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .data_div_o  (dataDiv),
    .div_zero_o  (divZero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal = checksTotal + 1;
    assert (observed === expected) checksPassed = checksPassed + 1;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // One full transaction; holdCycles>0 stalls the consumer and pokes in_valid mid-stall.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b,
                               input logic [11:0] expData, input logic expDz,
                               input string tag, input int holdCycles);
    expect_t e;
    int lat;
    @(posedge clk); #1;
    checkOutput({tag, "_ready"}, 32'(inReady), 32'd1);
    dataA   = a;
    dataB   = b;
    inValid = 1'b1;
    e.data  = expData;
    e.dz    = expDz;
    e.tag   = tag;
    expQ.push_back(e);
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd10);
    checkOutput({tag, "_queue"}, 32'(expQ.size()), 32'd1);
    if (expQ.size() > 0) e = expQ.pop_front();
    checkOutput({tag, "_data"}, 32'(dataDiv), 32'(e.data));
    checkOutput({tag, "_dz"}, 32'(divZero), 32'(e.dz));
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 1) begin
        dataA   = 12'h3C0;
        dataB   = 12'h3C0;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_hold_data"}, 32'(dataDiv), 32'(e.data));
      checkOutput({tag, "_hold_dz"}, 32'(divZero), 32'(e.dz));
      checkOutput({tag, "_hold_ready"}, 32'(inReady), 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput({tag, "_release"}, {30'd0, outValid, inReady}, 32'd1);
  endtask

  initial begin
    int spurious;
    logic [11:0] expBig;
    logic [11:0] expSmall;
`ifdef FLOAT_DIV_SAT_EN
    expBig   = 12'h7FF;
    expSmall = 12'h000;
`else
    expBig   = 12'h300;
    expSmall = 12'h480;
`endif
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataA    = '0;
    dataB    = '0;
    #12;
    checkOutput("reset_valid", 32'(outValid), 32'd0);
    checkOutput("reset_ready", 32'(inReady), 32'd1);
    checkOutput("reset_data", 32'(dataDiv), 32'd0);
    checkOutput("reset_dz", 32'(divZero), 32'd0);
    rst = 1'b0;

    applyStimulus(12'h3C0, 12'h3C0, 12'h3C0, 1'b0, "one_by_one", 0);
    applyStimulus(12'h420, 12'h3E0, 12'h400, 1'b0, "q7_set", 0);
    applyStimulus(12'hBC0, 12'h3E0, 12'hB95, 1'b0, "q7_clear", 0);
    applyStimulus(12'h3C0, 12'hC20, 12'hB55, 1'b0, "neg_divisor", 0);
    applyStimulus(12'h3C0, 12'h000, 12'h7FF, 1'b1, "div_zero", 0);
    applyStimulus(12'hBC0, 12'h000, 12'hFFF, 1'b1, "div_zero_neg", 0);
    applyStimulus(12'h000, 12'h000, 12'h7FF, 1'b1, "zero_by_zero", 0);
    applyStimulus(12'h000, 12'h3C0, 12'h000, 1'b0, "zero_dividend", 0);
    applyStimulus(12'h780, 12'h040, expBig, 1'b0, "exp_high", 0);
    applyStimulus(12'h040, 12'h780, expSmall, 1'b0, "exp_low", 0);

    applyStimulus(12'h420, 12'h3C0, 12'h420, 1'b0, "backpressure", 5);
    spurious = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (outValid) spurious++;
    end
    checkOutput("bp_no_second_accept", 32'(spurious), 32'd0);

    @(posedge clk); #1;
    dataA   = 12'h3C0;
    dataB   = 12'h3C0;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(inReady), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(inReady), 32'd1);
    checkOutput("abort_valid", 32'(outValid), 32'd0);
    checkOutput("abort_data", 32'(dataDiv), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(12'h420, 12'h3E0, 12'h400, 1'b0, "after_abort", 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
